z80fi_ld16_imm_tracker: RTL and testbench

Sequential decoder for the Z80 formal interface (Z80FI). It consumes the fetched-byte stream of the core under test and assembles every 16-bit immediate load into a retire record: LD BC/DE/HL/SP,nn and the prefixed LD IX/IY,nn. Each record carries the little-endian packed instruction word, its length, the destination register, nn and the start/next IP. It generalises the single-instruction IX/IY spec into one streaming block, adding prefix tracking, backpressure and statistics. It sits between the bus monitor and the per-instruction spec checkers.

---
 rtl/z80fi_ld16_imm_tracker.sv | 198 +++++++++++++++++++
 tb/tb_z80fi_ld16_imm_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_ld16_imm_tracker.sv
// z80fi_ld16_imm_tracker
// Streaming decoder for the Z80 formal interface. It watches the fetched-byte
// stream and assembles every 16-bit immediate load (LD BC/DE/HL/SP,nn and
// LD IX/IY,nn) into a retire record for the per-instruction checkers.
//
// Optional feature: define Z80FI_PREFIX_CHAIN_EN to let chained DD/FD
// prefixes accumulate (last prefix wins). Without it, a second prefix aborts
// and restarts decoding from that prefix.
//
// state | meaning
// IDLE  | waiting for an M1 opcode byte
// PFX   | DD/FD prefix latched, waiting for the 21 opcode
// LO    | waiting for the low immediate byte
// HI    | waiting for the high immediate byte
// OUT   | record presented, waiting for rec_ready_i
module z80fi_ld16_imm_tracker #(
    parameter int MAX_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_m1_i,
    input  logic [15:0]          byte_addr_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic [8*MAX_LEN-1:0] rec_insn_o,
    output logic [3:0]           rec_len_o,
    output logic [2:0]           rec_reg_o,
    output logic [15:0]          rec_nn_o,
    output logic [15:0]          rec_ip_o,
    output logic [15:0]          rec_ip_next_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     rec_count_o,
    output logic [CNT_W-1:0]     skip_count_o
);

    typedef enum logic [2:0] {S_IDLE, S_PFX, S_LO, S_HI, S_OUT} state_t;

    state_t               state_q, state_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic [3:0]           len_q, len_d;
    logic [2:0]           reg_q, reg_d;
    logic [15:0]          nn_q, nn_d;
    logic [15:0]          ip_q, ip_d;
    logic                 pfx_fd_q, pfx_fd_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     rec_cnt_q, skip_cnt_q;
    logic                 rec_inc, skip_inc;
    logic                 acc, do_start, do_append;
    logic                 byte_is_pfx, byte_is_ld;

    assign acc         = byte_valid_i && byte_ready_o;
    assign byte_is_pfx = (byte_data_i == 8'hDD) || (byte_data_i == 8'hFD);
    assign byte_is_ld  = (byte_data_i & 8'hCF) == 8'h01;

    // Next-state decode; do_start runs the IDLE decode so an aborting byte is reused.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        reg_d     = reg_q;
        nn_d      = nn_q;
        ip_d      = ip_q;
        pfx_fd_d  = pfx_fd_q;
        err_d     = 1'b0;
        rec_inc   = 1'b0;
        skip_inc  = 1'b0;
        do_start  = 1'b0;
        do_append = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (acc && byte_m1_i) do_start = 1'b1;
            end
            S_PFX: begin
                if (acc) begin
                    if (byte_data_i == 8'h21) begin
                        reg_d     = {2'b10, pfx_fd_q};
                        do_append = 1'b1;
                        state_d   = S_LO;
                    end else if (byte_is_pfx) begin
`ifdef Z80FI_PREFIX_CHAIN_EN
                        // Reject the prefix if opcode and nn could no longer fit.
                        if (int'(len_q) + 4 > MAX_LEN) begin
                            err_d    = 1'b1;
                            skip_inc = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            pfx_fd_d  = byte_data_i[5];
                            do_append = 1'b1;
                        end
`else
                        err_d    = 1'b1;
                        do_start = 1'b1;
`endif
                    end else begin
                        skip_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_LO, S_HI: begin
                if (acc) begin
                    if (byte_m1_i) begin
                        err_d    = 1'b1;
                        do_start = 1'b1;
                    end else begin
                        do_append = 1'b1;
                        if (state_q == S_LO) begin
                            nn_d[7:0] = byte_data_i;
                            state_d   = S_HI;
                        end else begin
                            nn_d[15:8] = byte_data_i;
                            state_d    = S_OUT;
                        end
                    end
                end
            end
            S_OUT: begin
                if (rec_ready_i) begin
                    rec_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_append) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (len_q == 4'(i)) buf_d[i*8 +: 8] = byte_data_i;
            end
            len_d = len_q + 4'd1;
        end

        if (do_start) begin
            if (byte_is_pfx || byte_is_ld) begin
                buf_d      = '0;
                buf_d[7:0] = byte_data_i;
                len_d      = 4'd1;
                ip_d       = byte_addr_i;
                nn_d       = '0;
            end
            if (byte_is_pfx) begin
                pfx_fd_d = byte_data_i[5];
                state_d  = S_PFX;
            end else if (byte_is_ld) begin
                reg_d   = {1'b0, byte_data_i[5:4]};
                state_d = S_LO;
            end else begin
                skip_inc = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    // Record registers and saturating statistics.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            len_q      <= '0;
            reg_q      <= '0;
            nn_q       <= '0;
            ip_q       <= '0;
            pfx_fd_q   <= 1'b0;
            err_q      <= 1'b0;
            rec_cnt_q  <= '0;
            skip_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            len_q    <= len_d;
            reg_q    <= reg_d;
            nn_q     <= nn_d;
            ip_q     <= ip_d;
            pfx_fd_q <= pfx_fd_d;
            err_q    <= err_d;
            if (rec_inc && (rec_cnt_q != '1)) rec_cnt_q <= rec_cnt_q + 1'b1;
            if (skip_inc && (skip_cnt_q != '1)) skip_cnt_q <= skip_cnt_q + 1'b1;
        end
    end

    assign byte_ready_o  = (state_q != S_OUT);
    assign rec_valid_o   = (state_q == S_OUT);
    assign rec_insn_o    = buf_q;
    assign rec_len_o     = len_q;
    assign rec_reg_o     = reg_q;
    assign rec_nn_o      = nn_q;
    assign rec_ip_o      = ip_q;
    assign rec_ip_next_o = ip_q + 16'(len_q);
    assign err_o         = err_q;
    assign rec_count_o   = rec_cnt_q;
    assign skip_count_o  = skip_cnt_q;

endmodule

// File: tb/tb_z80fi_ld16_imm_tracker.sv
// Directed bench for z80fi_ld16_imm_tracker; expectations are hand-computed.
module tb_z80fi_ld16_imm_tracker;

    localparam int MAX_LEN = 5;
    localparam int CNT_W   = 16;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    logic [7:0]           byte_data_i;
    logic                 byte_m1_i;
    logic [15:0]          byte_addr_i;
    logic                 rec_valid_o;
    logic                 rec_ready_i;
    logic [8*MAX_LEN-1:0] rec_insn_o;
    logic [3:0]           rec_len_o;
    logic [2:0]           rec_reg_o;
    logic [15:0]          rec_nn_o;
    logic [15:0]          rec_ip_o;
    logic [15:0]          rec_ip_next_o;
    logic                 err_o;
    logic [CNT_W-1:0]     rec_count_o;
    logic [CNT_W-1:0]     skip_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int w;

    z80fi_ld16_imm_tracker #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .byte_data_i  (byte_data_i),
        .byte_m1_i    (byte_m1_i),
        .byte_addr_i  (byte_addr_i),
        .rec_valid_o  (rec_valid_o),
        .rec_ready_i  (rec_ready_i),
        .rec_insn_o   (rec_insn_o),
        .rec_len_o    (rec_len_o),
        .rec_reg_o    (rec_reg_o),
        .rec_nn_o     (rec_nn_o),
        .rec_ip_o     (rec_ip_o),
        .rec_ip_next_o(rec_ip_next_o),
        .err_o        (err_o),
        .rec_count_o  (rec_count_o),
        .skip_count_o (skip_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one byte, wait (bounded) for byte_ready, return bubble cycles.
    task automatic send(input logic [7:0] d, input logic m1, input logic [15:0] a, output int waited);
        byte_valid_i = 1'b1;
        byte_data_i  = d;
        byte_m1_i    = m1;
        byte_addr_i  = a;
        waited       = 0;
        while (!byte_ready_o && waited < 20) begin
            tick();
            waited++;
        end
        if (!byte_ready_o) check("send_timeout", 64'(byte_ready_o), 64'd1);
        tick();
        byte_valid_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        byte_m1_i    = 1'b0;
        byte_addr_i  = 16'h0000;
        rec_ready_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(rec_valid_o), 64'd0);
        check("rst_ready", 64'(byte_ready_o), 64'd1);
        check("rst_insn", 64'(rec_insn_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_cnt", 64'({rec_count_o, skip_count_o}), 64'd0);
        reset_i = 1'b0;
        tick();

        // LD BC,1234 at 0100
        send(8'h01, 1'b1, 16'h0100, w);
        send(8'h34, 1'b0, 16'h0101, w);
        send(8'h12, 1'b0, 16'h0102, w);
        check("bc_valid", 64'(rec_valid_o), 64'd1);
        check("bc_ready_low", 64'(byte_ready_o), 64'd0);
        check("bc_reg", 64'(rec_reg_o), 64'd0);
        check("bc_nn", 64'(rec_nn_o), 64'h1234);
        check("bc_len", 64'(rec_len_o), 64'd3);
        check("bc_insn", 64'(rec_insn_o), 64'h123401);
        check("bc_ip", 64'(rec_ip_o), 64'h0100);
        check("bc_ip_next", 64'(rec_ip_next_o), 64'h0103);
        tick();
        check("bc_count", 64'(rec_count_o), 64'd1);
        check("bc_done", 64'(rec_valid_o), 64'd0);

        // LD IY,ABCD at FFFE, wrapping next IP
        send(8'hFD, 1'b1, 16'hFFFE, w);
        send(8'h21, 1'b1, 16'hFFFF, w);
        send(8'hCD, 1'b0, 16'h0000, w);
        send(8'hAB, 1'b0, 16'h0001, w);
        check("iy_reg", 64'(rec_reg_o), 64'd5);
        check("iy_nn", 64'(rec_nn_o), 64'hABCD);
        check("iy_len", 64'(rec_len_o), 64'd4);
        check("iy_insn", 64'(rec_insn_o), 64'hABCD21FD);
        check("iy_ip", 64'(rec_ip_o), 64'hFFFE);
        check("iy_ip_next", 64'(rec_ip_next_o), 64'h0002);
        tick();
        check("iy_count", 64'(rec_count_o), 64'd2);

        // Backpressure: LD DE,2000 held for 5 cycles
        rec_ready_i = 1'b0;
        send(8'h11, 1'b1, 16'h0200, w);
        send(8'h00, 1'b0, 16'h0201, w);
        send(8'h20, 1'b0, 16'h0202, w);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rec_valid_o), 64'd1);
            check("bp_ready", 64'(byte_ready_o), 64'd0);
            check("bp_nn", 64'(rec_nn_o), 64'h2000);
            check("bp_insn", 64'(rec_insn_o), 64'h200011);
            check("bp_reg", 64'(rec_reg_o), 64'd1);
            tick();
        end
        rec_ready_i = 1'b1;
        // Next byte (starts LD HL) waits exactly one bubble
        send(8'h21, 1'b1, 16'h0300, w);
        check("bp_bubble", 64'(w), 64'd1);
        check("bp_count", 64'(rec_count_o), 64'd3);

        // Abort: M1 byte 3E arrives in LO
        send(8'h3E, 1'b1, 16'h0301, w);
        check("ab_err", 64'(err_o), 64'd1);
        check("ab_skip", 64'(skip_count_o), 64'd1);
        check("ab_valid", 64'(rec_valid_o), 64'd0);
        tick();
        check("ab_err_pulse", 64'(err_o), 64'd0);
        check("ab_count", 64'(rec_count_o), 64'd3);

        // Prefix chain DD FD 21 00 80
        send(8'hDD, 1'b1, 16'h0400, w);
        send(8'hFD, 1'b1, 16'h0401, w);
`ifdef Z80FI_PREFIX_CHAIN_EN
        check("ch_err", 64'(err_o), 64'd0);
`else
        check("ch_err", 64'(err_o), 64'd1);
`endif
        send(8'h21, 1'b1, 16'h0402, w);
        send(8'h00, 1'b0, 16'h0403, w);
        send(8'h80, 1'b0, 16'h0404, w);
        check("ch_valid", 64'(rec_valid_o), 64'd1);
        check("ch_reg", 64'(rec_reg_o), 64'd5);
        check("ch_nn", 64'(rec_nn_o), 64'h8000);
        check("ch_ip_next", 64'(rec_ip_next_o), 64'h0405);
`ifdef Z80FI_PREFIX_CHAIN_EN
        check("ch_len", 64'(rec_len_o), 64'd5);
        check("ch_ip", 64'(rec_ip_o), 64'h0400);
        check("ch_insn", 64'(rec_insn_o), 64'h800021FDDD);
`else
        check("ch_len", 64'(rec_len_o), 64'd4);
        check("ch_ip", 64'(rec_ip_o), 64'h0401);
        check("ch_insn", 64'(rec_insn_o), 64'h800021FD);
`endif
        tick();
        check("ch_count", 64'(rec_count_o), 64'd4);

        // Asynchronous reset while in HI
        send(8'h31, 1'b1, 16'h0600, w);
        send(8'h00, 1'b0, 16'h0601, w);
        #2 reset_i = 1'b1;
        #1;
        check("ar_valid", 64'(rec_valid_o), 64'd0);
        check("ar_ready", 64'(byte_ready_o), 64'd1);
        check("ar_insn", 64'(rec_insn_o), 64'd0);
        check("ar_fields", 64'({rec_len_o, rec_reg_o, rec_nn_o, rec_ip_o}), 64'd0);
        check("ar_cnt", 64'({rec_count_o, skip_count_o}), 64'd0);
        check("ar_err", 64'(err_o), 64'd0);
        tick();
        reset_i = 1'b0;

        // LD SP,FFFF after reset
        send(8'h31, 1'b1, 16'h0700, w);
        send(8'hFF, 1'b0, 16'h0701, w);
        send(8'hFF, 1'b0, 16'h0702, w);
        check("sp_valid", 64'(rec_valid_o), 64'd1);
        check("sp_reg", 64'(rec_reg_o), 64'd3);
        check("sp_nn", 64'(rec_nn_o), 64'hFFFF);
        check("sp_len", 64'(rec_len_o), 64'd3);
        tick();
        check("sp_count", 64'(rec_count_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
